// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter feeding one UART transmitter with bounded bursts
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int MAX_BURST      = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_start,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_busy,
  input  logic                          tx_done,
  output logic                          owner_valid,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          timeout_err
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] TO_SAT    = {CW{1'b1}};

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [GW-1:0]         grant_id_q, grant_id_d;
  logic [GW-1:0]         last_ptr_q, last_ptr_d;
  logic                  owner_valid_q, owner_valid_d;
  logic [BW-1:0]         burst_cnt_q, burst_cnt_d;
  logic [CW-1:0]         to_cnt_q, to_cnt_d;

  logic win_found;
  int   win_i;
  int   own_i;

  // Rotating priority: scan starts just after the last released owner.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_i     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_ptr_q) + k) % NUM_REQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_i     = idx;
      end
    end
  end

  assign own_i = int'(grant_id_q);

  always_comb begin
    state_d       = state_q;
    tx_data_d     = tx_data_q;
    grant_id_d    = grant_id_q;
    last_ptr_d    = last_ptr_q;
    owner_valid_d = owner_valid_q;
    burst_cnt_d   = burst_cnt_q;
    to_cnt_d      = to_cnt_q;
    req_ready     = '0;
    tx_start      = 1'b0;
    timeout_err   = 1'b0;

    case (state_q)
      IDLE: begin
        if (win_found && !tx_busy) begin
          req_ready[win_i] = 1'b1;
          tx_data_d        = req_data[win_i*DATA_WIDTH +: DATA_WIDTH];
          grant_id_d       = GW'(win_i);
          owner_valid_d    = 1'b1;
          burst_cnt_d      = BW'(1);
          state_d          = LAUNCH;
        end
      end
      LAUNCH: begin
        tx_start = 1'b1;
        to_cnt_d = '0;
        state_d  = WAIT_DONE;
      end
      WAIT_DONE: begin
        // tx_done takes precedence over a timeout landing on the same cycle.
        if (tx_done) begin
          if (req_valid[own_i] && (burst_cnt_q < BURST_MAX)) begin
            req_ready[own_i] = 1'b1;
            tx_data_d        = req_data[own_i*DATA_WIDTH +: DATA_WIDTH];
            burst_cnt_d      = burst_cnt_q + 1'b1;
            state_d          = LAUNCH;
          end else begin
            last_ptr_d    = grant_id_q;
            owner_valid_d = 1'b0;
            burst_cnt_d   = '0;
            state_d       = IDLE;
          end
        end else if (to_cnt_q == TO_LAST) begin
          timeout_err   = 1'b1;
          last_ptr_d    = grant_id_q;
          owner_valid_d = 1'b0;
          burst_cnt_d   = '0;
          state_d       = IDLE;
        end else if (to_cnt_q != TO_SAT) begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A reset cycle must never hand out a byte or launch the transmitter.
    if (rst) begin
      req_ready   = '0;
      tx_start    = 1'b0;
      timeout_err = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      tx_data_q     <= '0;
      grant_id_q    <= '0;
      last_ptr_q    <= GW'(NUM_REQ - 1);
      owner_valid_q <= 1'b0;
      burst_cnt_q   <= '0;
      to_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      tx_data_q     <= tx_data_d;
      grant_id_q    <= grant_id_d;
      last_ptr_q    <= last_ptr_d;
      owner_valid_q <= owner_valid_d;
      burst_cnt_q   <= burst_cnt_d;
      to_cnt_q      <= to_cnt_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign grant_id    = grant_id_q;
  assign owner_valid = owner_valid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed and randomized checks of uart_tx_arbiter against a transaction-level model
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [NR-1:0]  req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]  req_ready;
  logic           tx_start;
  logic [DW-1:0]  tx_data;
  logic           tx_busy;
  logic           tx_done;
  logic           owner_valid;
  logic [1:0]     grant_id;
  logic           timeout_err;

  int nvec = 0;
  int nerr = 0;

  logic [7:0] rq [NR][$];
  int         exp_id [$];
  logic [7:0] exp_b [$];

  uart_tx_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .tx_done(tx_done), .owner_valid(owner_valid),
    .grant_id(grant_id), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic update_reqs();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = (rq[i].size() > 0);
      req_data[i*DW +: DW] = (rq[i].size() > 0) ? rq[i][0] : 8'h00;
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1; req_valid = '0; tx_done = 1'b0; tx_busy = 1'b0;
    for (int i = 0; i < NR; i++) rq[i].delete();
    next_cycle();
    rst = 1'b0;
  endtask

  // Transaction-level expectation: rotate from last owner, each owner sends up to MB queued bytes.
  task automatic build_expect();
    logic [7:0] mq [NR][$];
    int ptr, w, n, idx;
    for (int i = 0; i < NR; i++) mq[i] = rq[i];
    exp_id.delete(); exp_b.delete();
    ptr = NR - 1;
    while (1) begin
      w = -1;
      for (int k = 1; k <= NR; k++) begin
        idx = (ptr + k) % NR;
        if (w < 0 && mq[idx].size() > 0) w = idx;
      end
      if (w < 0) break;
      n = 0;
      while (n < MB && mq[w].size() > 0) begin
        exp_id.push_back(w);
        exp_b.push_back(mq[w].pop_front());
        n++;
      end
      ptr = w;
    end
  endtask

  task automatic run_scenario(input int budget);
    int cyc, done_at, acc_cyc, d;
    logic [NR-1:0] acc;
    bit finished;
    build_expect();
    update_reqs();
    cyc = 0; done_at = -1; acc_cyc = -100; finished = 1'b0;
    while (cyc < budget) begin
      @(negedge clk);
      check("rdy_onehot", 32'($countones(req_ready) <= 1), 1);
      check("rdy_without_valid", |(req_ready & ~req_valid), 0);
      check("spurious_timeout", timeout_err, 0);
      acc = req_ready & req_valid;
      if (acc != '0) acc_cyc = cyc;
      if (tx_start) begin
        if (exp_id.size() == 0) begin
          check("extra_tx_start", 1, 0);
        end else begin
          check("grant_order", grant_id, exp_id.pop_front());
          check("tx_byte", tx_data, exp_b.pop_front());
        end
        check("start_latency", cyc, acc_cyc + 1);
        d = $urandom_range(1, 12);
        done_at = cyc + d;
      end
      if (exp_id.size() == 0 && !owner_valid && !tx_done) begin
        finished = 1'b1;
        break;
      end
      next_cycle();
      cyc++;
      for (int i = 0; i < NR; i++) if (acc[i]) void'(rq[i].pop_front());
      update_reqs();
      tx_done = (cyc == done_at);
    end
    if (!finished) check("scenario_budget", 0, 1);
    check("bytes_left", exp_id.size(), 0);
    req_valid = '0;
    tx_done = 1'b0;
  endtask

  initial begin
    int tot, n;
    rst = 1'b1; tx_busy = 1'b0; tx_done = 1'b0;
    req_data = '0;
    req_data[15:8] = 8'h55; req_data[31:24] = 8'hA3;
    req_valid = 4'b1010;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("rst_ready", req_ready, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_owner", owner_valid, 0);
    check("rst_grant", grant_id, 0);
    check("rst_timeout", timeout_err, 0);

    // Two requesters pending, requester 1 is first after the reset pointer.
    next_cycle(); rst = 1'b0;
    @(negedge clk); check("first_ready", req_ready, 4'b0010);
    next_cycle(); req_valid = '0;
    @(negedge clk);
    check("first_start", tx_start, 1);
    check("first_data", tx_data, 8'h55);
    check("first_grant", grant_id, 1);
    check("first_owner", owner_valid, 1);
    next_cycle(); tx_done = 1'b1;
    @(negedge clk); check("single_start", tx_start, 0);
    next_cycle(); tx_done = 1'b0;
    @(negedge clk);
    check("release_owner", owner_valid, 0);
    check("grant_holds", grant_id, 1);
    check("data_holds", tx_data, 8'h55);

    // Transmitter busy blocks arbitration.
    next_cycle();
    tx_busy = 1'b1; req_valid = 4'b0001; req_data[7:0] = 8'h3C;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("busy_ready", req_ready, 0);
      check("busy_start", tx_start, 0);
      next_cycle();
    end
    tx_busy = 1'b0;
    @(negedge clk); check("unbusy_ready", req_ready, 4'b0001);
    next_cycle(); req_valid = 4'b0011; req_data[15:8] = 8'h66;
    @(negedge clk);
    check("unbusy_start", tx_start, 1);
    check("unbusy_data", tx_data, 8'h3C);

    // No tx_done: timeout fires 16 cycles after tx_start, priority moves on.
    for (int k = 1; k <= TO; k++) begin
      next_cycle();
      @(negedge clk);
      check("timeout_pulse", timeout_err, 32'(k == TO));
      if (k < TO) check("timeout_wait_ready", req_ready, 0);
    end
    next_cycle();
    @(negedge clk);
    check("timeout_single", timeout_err, 0);
    check("timeout_owner", owner_valid, 0);
    check("timeout_next_ready", req_ready, 4'b0010);
    next_cycle(); req_valid = '0;
    @(negedge clk);
    check("after_to_start", tx_start, 1);
    check("after_to_grant", grant_id, 1);
    check("after_to_data", tx_data, 8'h66);

    // tx_done on the timeout cycle wins.
    for (int k = 1; k <= TO; k++) begin
      next_cycle(); tx_done = (k == TO);
      @(negedge clk); check("tie_no_timeout", timeout_err, 0);
    end
    next_cycle(); tx_done = 1'b0;
    @(negedge clk);
    check("tie_owner", owner_valid, 0);
    check("tie_no_start", tx_start, 0);

    // Reset while requester 3 owns the transmitter.
    next_cycle(); req_valid = 4'b1000; req_data[7:0] = 8'h11;
    @(negedge clk); check("own3_ready", req_ready, 4'b1000);
    next_cycle(); req_valid = '0;
    @(negedge clk); check("own3_grant", grant_id, 3);
    next_cycle(); rst = 1'b1; req_valid = 4'b1111; tx_done = 1'b1;
    @(negedge clk);
    check("midrst_ready", req_ready, 0);
    check("midrst_start", tx_start, 0);
    next_cycle(); rst = 1'b0; tx_done = 1'b0;
    @(negedge clk);
    check("midrst_owner", owner_valid, 0);
    check("midrst_grant", grant_id, 0);
    check("midrst_data", tx_data, 0);
    check("midrst_restart", req_ready, 4'b0001);
    next_cycle(); req_valid = '0;
    @(negedge clk); check("midrst_byte", tx_data, 8'h11);
    next_cycle(); tx_done = 1'b1;
    next_cycle(); tx_done = 1'b0;

    // Requester 2 alone with six bytes: burst of MB, then re-arbitration.
    reset_dut();
    for (int j = 0; j < 6; j++) rq[2].push_back(8'(8'h20 + j));
    run_scenario(2000);

    // One byte each: strict rotation 0,1,2,3.
    reset_dut();
    for (int i = 0; i < NR; i++) rq[i].push_back(8'(8'hC0 + i));
    run_scenario(2000);

    for (int s = 0; s < 5; s++) begin
      reset_dut();
      tot = 0;
      for (int i = 0; i < NR; i++) begin
        n = $urandom_range(0, 7);
        for (int j = 0; j < n; j++) rq[i].push_back(8'($urandom));
        tot += n;
      end
      if (tot == 0) rq[1].push_back(8'hA5);
      run_scenario(3000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
